// File: rtl/ysyx_040750_radix2_mul.sv
// Radix-2 sequential 64x64 multiplier (signed/unsigned per operand); 64 BUSY cycles, or fewer with
// YSYX_040750_MUL_EARLY_TERM_EN defined. mul_ready is high only in IDLE; mul_flush and rst abandon any operation.
module ysyx_040750_radix2_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    input  logic [1:0]  mul_signed,
    input  logic        mul_valid,
    input  logic        mul_flush,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   acc;
    logic [127:0]   a_sh;
    logic [63:0]    b_sh;
    logic           neg;
    logic           accept;
    logic           last;
    logic           a_neg_in;
    logic           b_neg_in;
    logic [63:0]    a_mag;
    logic [63:0]    b_mag;
    logic [127:0]   acc_add;
    logic [127:0]   res_nxt;

    assign a_neg_in  = multiplicand[63] & mul_signed[1];
    assign b_neg_in  = multiplier[63] & mul_signed[0];
    // 0x8000...0 negates to itself, which read as unsigned is the magnitude 2^63
    assign a_mag     = a_neg_in ? (~multiplicand + 64'd1) : multiplicand;
    assign b_mag     = b_neg_in ? (~multiplier + 64'd1) : multiplier;
    assign acc_add   = b_sh[0] ? (acc + a_sh) : acc;
    assign res_nxt   = neg ? (~acc_add + 128'd1) : acc_add;

    assign accept    = mul_valid & (state == IDLE) & ~mul_flush;
    assign mul_ready = (state == IDLE);
    assign out_valid = (state == DONE) & ~mul_flush & ~rst;

`ifdef YSYX_040750_MUL_EARLY_TERM_EN
    // Stop once no set bits remain in the multiplier after this cycle's shift
    assign last = (b_sh[63:1] == 63'd0);
`else
    logic [5:0] cnt;

    assign last = (cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt <= 6'd0;
        end else if (state == BUSY) begin
            cnt <= cnt + 6'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: begin
                if (mul_flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 128'd0;
            a_sh      <= 128'd0;
            b_sh      <= 64'd0;
            neg       <= 1'b0;
            result_hi <= 64'd0;
            result_lo <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc  <= 128'd0;
                a_sh <= {64'd0, a_mag};
                b_sh <= b_mag;
                neg  <= a_neg_in ^ b_neg_in;
            end else if (state == BUSY) begin
                acc  <= acc_add;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                // Results only move on DONE entry so they stay stable until the next product
                if (state_nxt == DONE) begin
                    {result_hi, result_lo} <= res_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040750_radix2_mul.sv
// Self-checking bench for ysyx_040750_radix2_mul: directed and random products against a
// 128-bit arithmetic reference, plus flush, reset and latency scenarios.
module tb_ysyx_040750_radix2_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic [1:0]  mul_signed;
    logic        mul_valid;
    logic        mul_flush;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int nvec = 0;
    int nerr = 0;

    ysyx_040750_radix2_mul dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_signed   (mul_signed),
        .mul_valid    (mul_valid),
        .mul_flush    (mul_flush),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_prod(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = {{64{a[63] & s[1]}}, a};
        eb = {{64{b[63] & s[0]}}, b};
        return ea * eb;
    endfunction

    function automatic int model_lat(input logic [63:0] b, input logic [1:0] s);
`ifdef YSYX_040750_MUL_EARLY_TERM_EN
        logic [63:0] mag;
        int k;
        mag = (b[63] & s[0]) ? (64'd0 - b) : b;
        k = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) k = i + 1;
        return ((k < 1) ? 1 : k) + 1;
`else
        return 65;
`endif
    endfunction

    // Issues one request, then reports what the DUT did; the tests judge the observations.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                          input bit garbage, output int lat, output int ready_lo,
                          output logic [63:0] hi, output logic [63:0] lo,
                          output logic ready_after, output logic [63:0] hi_after,
                          output logic [63:0] lo_after);
        lat = -1; ready_lo = 0; hi = '0; lo = '0;
        @(negedge clk);
        multiplicand = a; multiplier = b; mul_signed = s; mul_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!mul_ready) ready_lo++;
            if (out_valid) begin
                lat = c; hi = result_hi; lo = result_lo;
                mul_valid = 1'b0;
                break;
            end
            if (garbage) begin
                mul_valid    = 1'($urandom);
                multiplicand = {$urandom, $urandom};
                multiplier   = {$urandom, $urandom};
                mul_signed   = 2'($urandom);
            end else begin
                mul_valid = 1'b0;
            end
        end
        mul_valid = 1'b0;
        @(negedge clk);
        ready_after = mul_ready; hi_after = result_hi; lo_after = result_lo;
    endtask

    task automatic test_reset;
        rst = 1'b1; mul_valid = 1'b0; mul_flush = 1'b0;
        multiplicand = '0; multiplier = '0; mul_signed = '0;
        repeat (3) @(negedge clk);
        nvec++; if (mul_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b want=1", mul_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        nvec++; if (result_hi !== 64'd0) begin nerr++; $display("FAIL reset_hi got=%h want=0", result_hi); end
        nvec++; if (result_lo !== 64'd0) begin nerr++; $display("FAIL reset_lo got=%h want=0", result_lo); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [63:0] ta [8];
        logic [63:0] tb [8];
        logic [1:0]  ts [8];
        logic [63:0] thi [8];
        logic [63:0] tlo [8];
        int lat, rlo;
        logic [63:0] hi, lo, hia, loa;
        logic ra;
        ta[0] = 64'd7;                  tb[0] = 64'd6;                  ts[0] = 2'b00; thi[0] = 64'd0;                  tlo[0] = 64'd42;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFD; tb[1] = 64'd5;                 ts[1] = 2'b11; thi[1] = 64'hFFFF_FFFF_FFFF_FFFF; tlo[1] = 64'hFFFF_FFFF_FFFF_FFF1;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFD; tb[2] = 64'd5;                 ts[2] = 2'b00; thi[2] = 64'd4;                  tlo[2] = 64'hFFFF_FFFF_FFFF_FFF1;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h8000_0000_0000_0000; ts[3] = 2'b11; thi[3] = 64'h4000_0000_0000_0000; tlo[3] = 64'd0;
        ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'h8000_0000_0000_0000; ts[4] = 2'b10; thi[4] = 64'hC000_0000_0000_0000; tlo[4] = 64'd0;
        ta[5] = 64'd100;                tb[5] = 64'd0;                  ts[5] = 2'b00; thi[5] = 64'd0;                  tlo[5] = 64'd0;
        ta[6] = 64'd100;                tb[6] = 64'd5;                  ts[6] = 2'b00; thi[6] = 64'd0;                  tlo[6] = 64'd500;
        ta[7] = 64'hFFFF_FFFF_FFFF_FFFF; tb[7] = 64'hFFFF_FFFF_FFFF_FFFF; ts[7] = 2'b00; thi[7] = 64'hFFFF_FFFF_FFFF_FFFE; tlo[7] = 64'd1;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], (i % 2) == 1, lat, rlo, hi, lo, ra, hia, loa);
            nvec++; if (lat !== model_lat(tb[i], ts[i])) begin nerr++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, model_lat(tb[i], ts[i])); end
            nvec++; if (hi !== thi[i]) begin nerr++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, thi[i]); end
            nvec++; if (lo !== tlo[i]) begin nerr++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, tlo[i]); end
            nvec++; if (rlo !== model_lat(tb[i], ts[i])) begin nerr++; $display("FAIL dir%0d_ready_low_cycles got=%0d want=%0d", i, rlo, model_lat(tb[i], ts[i])); end
            nvec++; if (ra !== 1'b1) begin nerr++; $display("FAIL dir%0d_ready_after got=%b want=1", i, ra); end
        end
    endtask

    task automatic test_random;
        logic [63:0] a, b, hi, lo, hia, loa;
        logic [1:0]  s;
        logic [127:0] p;
        int lat, rlo;
        logic ra;
        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = 64'($urandom_range(0, 255));
                2: begin
                    b = 64'h8000_0000_0000_0000;
                    a = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
                end
                default: b = {32'd0, $urandom};
            endcase
            p = model_prod(a, b, s);
            run_op(a, b, s, (i % 2) == 0, lat, rlo, hi, lo, ra, hia, loa);
            nvec++; if (lat !== model_lat(b, s)) begin nerr++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, model_lat(b, s)); end
            nvec++; if ({hi, lo} !== p) begin nerr++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got=%h_%h want=%h", i, a, b, s, hi, lo, p); end
            nvec++; if ({hia, loa} !== p) begin nerr++; $display("FAIL rnd%0d_held got=%h_%h want=%h", i, hia, loa, p); end
            nvec++; if (ra !== 1'b1) begin nerr++; $display("FAIL rnd%0d_ready_after got=%b want=1", i, ra); end
        end
    endtask

    task automatic test_flush;
        int lat, rlo;
        logic [63:0] hi, lo, hia, loa;
        logic ra;
        logic seen;
        // kill mid-BUSY, then a new request two cycles later
        seen = 1'b0;
        @(negedge clk);
        multiplicand = 64'd123456789; multiplier = 64'hF000_0000_0000_1234; mul_signed = 2'b00; mul_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            seen |= out_valid;
            mul_valid = 1'b0;
            mul_flush = (c == 30);
        end
        nvec++; if (mul_ready !== 1'b1) begin nerr++; $display("FAIL flush_busy_ready got=%b want=1", mul_ready); end
        run_op(64'd2, 64'd3, 2'b00, 1'b0, lat, rlo, hi, lo, ra, hia, loa);
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL flush_busy_no_valid got=%b want=0", seen); end
        nvec++; if (lat !== model_lat(64'd3, 2'b00)) begin nerr++; $display("FAIL flush_second_latency got=%0d want=%0d", lat, model_lat(64'd3, 2'b00)); end
        nvec++; if (lo !== 64'd6) begin nerr++; $display("FAIL flush_second_lo got=%h want=6", lo); end
        nvec++; if (hi !== 64'd0) begin nerr++; $display("FAIL flush_second_hi got=%h want=0", hi); end

        // kill in the DONE cycle suppresses that cycle's strobe
        seen = 1'b0;
        @(negedge clk);
        multiplicand = 64'd99; multiplier = 64'h8000_0000_0000_0001; mul_signed = 2'b00; mul_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            mul_valid = 1'b0;
            if (c == 65) begin
                mul_flush = 1'b1;
                #1;
            end
            seen |= out_valid;
        end
        @(negedge clk);
        mul_flush = 1'b0;
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL flush_done_no_valid got=%b want=0", seen); end
        nvec++; if (mul_ready !== 1'b1) begin nerr++; $display("FAIL flush_done_ready got=%b want=1", mul_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_done_after_valid got=%b want=0", out_valid); end

        // flush beats valid in IDLE
        mul_valid = 1'b1; mul_flush = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0; mul_flush = 1'b0;
        nvec++; if (mul_ready !== 1'b1) begin nerr++; $display("FAIL flush_idle_priority_ready got=%b want=1", mul_ready); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        multiplicand = 64'hDEAD_BEEF; multiplier = 64'h8000_0000_0000_0003; mul_signed = 2'b00; mul_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            seen |= out_valid;
            mul_valid = 1'b0;
        end
        rst = 1'b1; mul_valid = 1'b1; mul_flush = 1'b1;
        @(negedge clk);
        seen |= out_valid;
        rst = 1'b0; mul_valid = 1'b0; mul_flush = 1'b0;
        nvec++; if (mul_ready !== 1'b1) begin nerr++; $display("FAIL rst_mid_ready got=%b want=1", mul_ready); end
        nvec++; if (result_hi !== 64'd0) begin nerr++; $display("FAIL rst_mid_hi got=%h want=0", result_hi); end
        nvec++; if (result_lo !== 64'd0) begin nerr++; $display("FAIL rst_mid_lo got=%h want=0", result_lo); end
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL rst_mid_no_valid got=%b want=0", seen); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
